// File: rtl/mb_scheduler.sv
// Macroblock scheduler: walks a frame in raster order, launching the motion-estimation
// controller once per 16x16 macroblock and tracking handshake timeouts and frame cycle count.
module mb_scheduler #(
    parameter int MB_COLS     = 4,
    parameter int MB_ROWS     = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_go,
    input  logic [1:0]  r_cfg,
    input  logic        abort,
    input  logic        me_start,
    output logic        me_go,
    output logic [1:0]  me_r,
    output logic [7:0]  mb_x,
    output logic [7:0]  mb_y,
    output logic [15:0] cur_base,
    output logic [3:0]  mb_edge,    // {top,bottom,left,right}; "edge" is a reserved word
    output logic        frame_busy,
    output logic        frame_done,
    output logic        err,
    output logic [23:0] cyc_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_NEXT      = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [7:0]  LAST_COL  = 8'(MB_COLS - 1);
    localparam logic [7:0]  LAST_ROW  = 8'(MB_ROWS - 1);
    localparam logic [15:0] ACK_LIMIT = 16'(ACK_TIMEOUT);
    localparam logic [23:0] CYC_MAX   = 24'hFF_FFFF;

    state_t      state_r;
    state_t      next_s;
    logic        accept_s;
    logic        advance_s;
    logic        timeout_s;
    logic        last_mb_s;
    logic        ack_expire_s;
    logic [15:0] timer_r;
    logic [15:0] mb_index_r;
    logic [15:0] index_inc_s;
    logic [7:0]  mb_x_r;
    logic [7:0]  mb_y_r;
    logic [15:0] cur_base_r;
    logic [1:0]  me_r_r;
    logic        me_go_r;
    logic        frame_done_r;
    logic        frame_busy_r;
    logic        err_r;
    logic [23:0] cyc_count_r;

    assign last_mb_s    = (mb_x_r == LAST_COL) && (mb_y_r == LAST_ROW);
    assign ack_expire_s = ((timer_r + 16'd1) == ACK_LIMIT);
    assign index_inc_s  = mb_index_r + 16'd1;

    // Next-state logic; abort overrides every transition in the active states.
    always_comb begin
        next_s    = state_r;
        accept_s  = 1'b0;
        advance_s = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                // A still-busy controller (aborted frame) blocks acceptance.
                if (frame_go && !me_start) begin
                    next_s   = S_LAUNCH;
                    accept_s = 1'b1;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (abort) next_s = S_FINISH;
                else       next_s = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (abort) begin
                    next_s = S_FINISH;
                end else if (me_start) begin
                    next_s = S_WAIT_DONE;
                end else if (ack_expire_s) begin
                    next_s    = S_FINISH;
                    timeout_s = 1'b1;
                end else begin
                    next_s = S_WAIT_ACK;
                end
            end
            S_WAIT_DONE: begin
                if (abort)          next_s = S_FINISH;
                else if (!me_start) next_s = S_NEXT;
                else                next_s = S_WAIT_DONE;
            end
            S_NEXT: begin
                if (abort) begin
                    next_s = S_FINISH;
                end else if (last_mb_s) begin
                    next_s = S_FINISH;
                end else begin
                    next_s    = S_LAUNCH;
                    advance_s = 1'b1;
                end
            end
            S_FINISH: next_s = S_IDLE;
            default:  next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_r <= S_IDLE;
        else        state_r <= next_s;
    end

    // State decodes registered one cycle early so they align with the state they flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            me_go_r      <= 1'b0;
            frame_done_r <= 1'b0;
            frame_busy_r <= 1'b0;
        end else begin
            me_go_r      <= (next_s == S_LAUNCH);
            frame_done_r <= (next_s == S_FINISH);
            frame_busy_r <= (next_s != S_IDLE);
        end
    end

    // Acknowledge timer: cleared on launch, counts idle cycles while awaiting me_start.
    always_ff @(posedge clk) begin
        if (!reset)                                 timer_r <= 16'd0;
        else if (state_r == S_LAUNCH)               timer_r <= 16'd0;
        else if (state_r == S_WAIT_ACK && !me_start) timer_r <= timer_r + 16'd1;
        else                                        timer_r <= timer_r;
    end

    // Macroblock position, linear index, base address and search range.
    always_ff @(posedge clk) begin
        if (!reset || accept_s) begin
            mb_x_r     <= 8'd0;
            mb_y_r     <= 8'd0;
            mb_index_r <= 16'd0;
            cur_base_r <= 16'd0;
            me_r_r     <= !reset ? 2'd0 : r_cfg;
        end else if (advance_s) begin
            if (mb_x_r == LAST_COL) begin
                mb_x_r <= 8'd0;
                mb_y_r <= mb_y_r + 8'd1;
            end else begin
                mb_x_r <= mb_x_r + 8'd1;
            end
            mb_index_r <= index_inc_s;
            cur_base_r <= {index_inc_s[10:0], 5'b0_0000};
        end
    end

    // Sticky timeout flag and saturating frame cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_r       <= 1'b0;
            cyc_count_r <= 24'd0;
        end else if (accept_s) begin
            err_r       <= 1'b0;
            cyc_count_r <= 24'd0;
        end else begin
            if (timeout_s) err_r <= 1'b1;
            if (state_r != S_IDLE && cyc_count_r != CYC_MAX)
                cyc_count_r <= cyc_count_r + 24'd1;
        end
    end

    assign me_go      = me_go_r;
    assign frame_done = frame_done_r;
    assign frame_busy = frame_busy_r;
    assign err        = err_r;
    assign me_r       = me_r_r;
    assign mb_x       = mb_x_r;
    assign mb_y       = mb_y_r;
    assign cur_base   = cur_base_r;
    assign cyc_count  = cyc_count_r;
    assign mb_edge    = {(mb_y_r == 8'd0), (mb_y_r == LAST_ROW), (mb_x_r == 8'd0), (mb_x_r == LAST_COL)};

endmodule

// File: tb/tb_mb_scheduler.sv
// Bench for mb_scheduler: a 4x4 instance driven by randomized controller timing against a
// frame-level cycle model, plus a 1x1 instance for the single-macroblock corner.
module tb_mb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_go, abort, me_start;
    logic [1:0]  r_cfg;
    logic        me_go, frame_busy, frame_done, err;
    logic [1:0]  me_r;
    logic [7:0]  mb_x, mb_y;
    logic [15:0] cur_base;
    logic [3:0]  mb_edge;
    logic [23:0] cyc_count;

    logic        b_frame_go, b_abort, b_me_start;
    logic [1:0]  b_r_cfg;
    logic        b_me_go, b_frame_busy, b_frame_done, b_err;
    logic [1:0]  b_me_r;
    logic [7:0]  b_mb_x, b_mb_y;
    logic [15:0] b_cur_base;
    logic [3:0]  b_mb_edge;
    logic [23:0] b_cyc_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mb_scheduler #(.MB_COLS(4), .MB_ROWS(4), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .frame_go(frame_go), .r_cfg(r_cfg), .abort(abort),
        .me_start(me_start), .me_go(me_go), .me_r(me_r), .mb_x(mb_x), .mb_y(mb_y),
        .cur_base(cur_base), .mb_edge(mb_edge), .frame_busy(frame_busy),
        .frame_done(frame_done), .err(err), .cyc_count(cyc_count)
    );

    mb_scheduler #(.MB_COLS(1), .MB_ROWS(1), .ACK_TIMEOUT(4)) dut_one (
        .clk(clk), .reset(reset), .frame_go(b_frame_go), .r_cfg(b_r_cfg), .abort(b_abort),
        .me_start(b_me_start), .me_go(b_me_go), .me_r(b_me_r), .mb_x(b_mb_x), .mb_y(b_mb_y),
        .cur_base(b_cur_base), .mb_edge(b_mb_edge), .frame_busy(b_frame_busy),
        .frame_done(b_frame_done), .err(b_err), .cyc_count(b_cyc_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_a();
        chk("rst_me_go", me_go, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_busy", frame_busy, 0);
        chk("rst_err", err, 0);
        chk("rst_me_r", me_r, 0);
        chk("rst_mb_x", mb_x, 0);
        chk("rst_mb_y", mb_y, 0);
        chk("rst_cur_base", cur_base, 0);
        chk("rst_cyc_count", cyc_count, 0);
        chk("rst_edge", mb_edge, 4'b1010);
    endtask

    // Current cycle is the launch of macroblock idx; controller answers after lat, busy for hold.
    task automatic do_mb(input int idx, input int lat, input int hold, input logic [1:0] rc);
        int x, y;
        logic [3:0] e;
        x = idx % 4;
        y = idx / 4;
        e = {(y == 0), (y == 3), (x == 0), (x == 3)};
        chk("me_go_launch", me_go, 1);
        chk("mb_x", mb_x, x);
        chk("mb_y", mb_y, y);
        chk("cur_base", cur_base, idx * 32);
        chk("edge", mb_edge, e);
        chk("me_r", me_r, rc);
        chk("frame_busy", frame_busy, 1);
        repeat (lat) tick();
        me_start = 1'b1;
        repeat (hold) tick();
        me_start = 1'b0;
        tick();
        chk("me_go_next", me_go, 0);
        tick();
        if (idx == 15) chk("frame_done", frame_done, 1);
        else           chk("me_go_relaunch", me_go, 1);
    endtask

    // Whole frame: each macroblock costs launch + lat + hold + step cycles, plus one finish cycle.
    task automatic frame_a(input logic [1:0] rc, input bit rnd, input bit hold_go, input bit launched);
        int total, lat, hold;
        total = 0;
        if (!launched) begin
            frame_go = 1'b1;
            r_cfg    = rc;
            tick();
        end
        if (!hold_go) frame_go = 1'b0;
        chk("cyc_start", cyc_count, 0);
        for (int i = 0; i < 16; i++) begin
            lat  = rnd ? int'($urandom_range(8, 1)) : 2;
            hold = rnd ? int'($urandom_range(6, 1)) : 10;
            do_mb(i, lat, hold, rc);
            total += lat + hold + 2;
        end
        chk("frame_err", err, 0);
        tick();
        chk("idle_frame_done", frame_done, 0);
        chk("idle_frame_busy", frame_busy, 0);
        chk("idle_me_go", me_go, 0);
        chk("cyc_count", cyc_count, total + 1);
    endtask

    initial begin
        logic [1:0] rc;
        reset = 1'b0; frame_go = 1'b0; abort = 1'b0; me_start = 1'b0; r_cfg = 2'd0;
        b_frame_go = 1'b0; b_abort = 1'b0; b_me_start = 1'b0; b_r_cfg = 2'd0;
        tick();
        tick();
        chk_reset_a();
        reset = 1'b1;
        tick();

        // Single-macroblock frame.
        b_frame_go = 1'b1; b_r_cfg = 2'd1;
        tick();
        b_frame_go = 1'b0;
        chk("one_me_go", b_me_go, 1);
        chk("one_edge", b_mb_edge, 4'b1111);
        chk("one_cur_base", b_cur_base, 0);
        repeat (2) tick();
        b_me_start = 1'b1;
        repeat (3) tick();
        b_me_start = 1'b0;
        tick();
        chk("one_no_done_early", b_frame_done, 0);
        tick();
        chk("one_frame_done", b_frame_done, 1);
        chk("one_no_relaunch", b_me_go, 0);
        tick();
        chk("one_idle", b_frame_busy, 0);

        // Nominal frame, then randomized controller timing.
        frame_a(2'd2, 1'b0, 1'b0, 1'b0);
        repeat (3) begin
            rc = 2'($urandom_range(3, 0));
            frame_a(rc, 1'b1, 1'b0, 1'b0);
        end

        // Controller never answers: timeout.
        frame_go = 1'b1; r_cfg = 2'd1;
        tick();
        frame_go = 1'b0;
        chk("to_me_go", me_go, 1);
        repeat (8) tick();
        chk("to_err_early", err, 0);
        chk("to_done_early", frame_done, 0);
        tick();
        chk("to_err", err, 1);
        chk("to_frame_done", frame_done, 1);
        tick();
        chk("to_err_sticky", err, 1);
        chk("to_cyc_count", cyc_count, 10);
        frame_go = 1'b1; r_cfg = 2'd3;
        tick();
        frame_go = 1'b0;
        chk("to_err_cleared", err, 0);

        // Abort during the fifth macroblock's busy phase.
        for (int i = 0; i < 4; i++) do_mb(i, 2, 3, 2'd3);
        chk("ab_mb_x", mb_x, 0);
        chk("ab_mb_y", mb_y, 1);
        repeat (2) tick();
        me_start = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_frame_done", frame_done, 1);
        chk("ab_hold_x", mb_x, 0);
        chk("ab_hold_y", mb_y, 1);
        tick();
        chk("ab_idle", frame_busy, 0);
        frame_go = 1'b1;
        repeat (3) begin
            tick();
            chk("ab_blocked_go", me_go, 0);
            chk("ab_blocked_busy", frame_busy, 0);
        end
        me_start = 1'b0;
        tick();
        frame_go = 1'b0;
        chk("ab_accept", me_go, 1);

        // Reset pulse in the busy phase abandons the frame.
        repeat (2) tick();
        me_start = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_reset_a();
        reset = 1'b1;
        me_start = 1'b0;
        repeat (3) begin
            tick();
            chk("rs_no_done", frame_done, 0);
            chk("rs_no_go", me_go, 0);
        end

        // frame_go held high: back-to-back frames.
        rc = 2'($urandom_range(3, 0));
        frame_a(rc, 1'b1, 1'b1, 1'b0);
        tick();
        chk("b2b_launch", me_go, 1);
        frame_go = 1'b0;
        frame_a(rc, 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
